bs_drvr_endpoint: RTL and testbench
===================================

BS_DRVR_ENDPOINT -- requirements
Module: bs_drvr_endpoint

Interface
REQ-001 Parameter bits, default 32: packet width; bits[bits-1:bits-8] are the destination address.
REQ-002 Parameter depth, default 8: entries per FIFO (TX and RX); power of two, at least 2.
REQ-003 Parameter id, default 8'h00: this endpoint's bus address.
REQ-004 Parameter broadcast, default {8{1'b1}}: destination value accepted by every endpoint.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tx_data  input  bits  local packet to send.
REQ-008 tx_valid  input  1  local write request.
REQ-009 tx_ready  output  1  TX FIFO can accept a write.
REQ-010 pndng  output  1  TX FIFO non-empty; bus-side request flag.
REQ-011 pop  input  1  bus has consumed D_pop.
REQ-012 D_pop  output  bits  TX FIFO head, first-word fall-through.
REQ-013 push  input  1  bus is delivering D_push.
REQ-014 D_push  input  bits  packet delivered by the bus.
REQ-015 rx_data  output  bits  RX FIFO head, first-word fall-through.
REQ-016 rx_valid  output  1  RX FIFO non-empty.
REQ-017 rx_ready  input  1  local reader consumes rx_data.
REQ-018 rx_drop_cnt  output  8  count of addressed packets dropped because RX FIFO was full.

Function
REQ-019 TX write SHALL occur on an edge where tx_valid && tx_ready; tx_ready SHALL equal (tx_count < depth).
REQ-020 TX count SHALL be +1 on write only, -1 on effective pop only, and unchanged on simultaneous write and pop.
REQ-021 pndng SHALL equal (tx_count != 0); D_pop SHALL show the oldest entry, or 0 when empty.
REQ-022 pop while pndng=0 SHALL be ignored, with no pointer or count change.
REQ-023 Push SHALL be addressed when D_push[bits-1:bits-8] equals id or broadcast; unaddressed pushes SHALL be discarded silently without counting.
REQ-024 An addressed push SHALL be stored iff rx_count < depth before the edge; a same-cycle local read SHALL NOT free a slot for it.
REQ-025 An addressed push with rx_count == depth SHALL be dropped, incrementing rx_drop_cnt, which saturates at 8'hFF.
REQ-026 RX read SHALL occur on rx_valid && rx_ready; rx_valid = (rx_count != 0); rx_data SHALL be the head, or 0 when empty.
REQ-027 RX count SHALL stay unchanged on simultaneous store and read.
REQ-028 Pointers SHALL wrap modulo depth; ordering SHALL be strict FIFO in both directions.
REQ-029 Latency: a TX write SHALL raise pndng the next cycle; a stored push SHALL raise rx_valid the next cycle; there is no combinational path from tx_valid to pndng or from push to rx_valid.
REQ-030 TX and RX paths SHALL be fully independent; all four operations SHALL be allowed in one cycle.

Reset
REQ-031 reset=1 SHALL immediately clear both FIFOs' pointers and counts and clear rx_drop_cnt, independent of clk.
REQ-032 During and after reset: pndng=0, D_pop=0, tx_ready=1, rx_valid=0, rx_data=0, rx_drop_cnt=0; FIFO storage need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all queued packets; the first operation after deassertion SHALL behave as on an empty endpoint.

Verification
REQ-034 Write 0x00000011, then 0x00000022 via TX -> pndng=1 one cycle after the first write, D_pop=0x00000011; after a pop, D_pop=0x00000022; after a second pop, pndng=0 and D_pop=0.
REQ-035 id=8'h03: push 0x03ABCDEF, 0xFF000001 and 0x05000000 -> RX holds 0x03ABCDEF then 0xFF000001; 0x05000000 is discarded and rx_drop_cnt stays 0.
REQ-036 depth=8: fill RX with 8 addressed pushes, push a 9th while rx_ready=1 -> 9th dropped, rx_drop_cnt=1, the 8 originals are read out in order.
REQ-037 TX full (8 entries) with tx_valid=1 and pop=1 together -> tx_ready=0, no write, count becomes 7; pop on empty -> no change.
REQ-038 Load 5 TX and 3 RX packets, then assert reset asynchronously between edges -> outputs reach reset values before the next edge; after release, a single write yields pndng=1 with that packet at D_pop.
REQ-039 Random concurrent TX/RX traffic for 10000 cycles vs a scoreboard -> no loss or reordering beyond counted drops, and rx_drop_cnt saturates at 255.

Source files
------------

// File: rtl/bs_drvr_endpoint.sv
// Bus driver endpoint: a TX FIFO that the bus drains via pndng/pop/D_pop, and an
// address-filtered RX FIFO that the bus fills via push/D_push, with a saturating drop counter.
module bs_drvr_endpoint #(
    parameter int          bits      = 32,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = {8{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    // local transmit side
    input  logic [bits-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    // bus side of the TX FIFO
    output logic            pndng,
    input  logic            pop,
    output logic [bits-1:0] D_pop,
    // bus side of the RX FIFO
    input  logic            push,
    input  logic [bits-1:0] D_push,
    // local receive side
    output logic [bits-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [7:0]      rx_drop_cnt
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = ptr_w + 1;

    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [cnt_w-1:0] cnt_t;

    localparam cnt_t depth_c = cnt_t'(depth);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [bits-1:0] tx_mem [depth];
    ptr_t            tx_wr_ptr;
    ptr_t            tx_rd_ptr;
    cnt_t            tx_count;
    logic            tx_write;
    logic            tx_pop;

    assign tx_ready = (tx_count < depth_c);
    assign pndng    = (tx_count != '0);
    assign tx_write = tx_valid && tx_ready;
    // A pop against an empty FIFO is ignored so pointers never run ahead.
    assign tx_pop   = pop && pndng;
    assign D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;

    // NOTE: storage arrays carry no reset; validity is tracked by the counts,
    // so clearing them would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (tx_write) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_write) begin
                tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
            end
            case ({tx_write, tx_pop})
                2'b10:   tx_count <= tx_count + cnt_t'(1);
                2'b01:   tx_count <= tx_count - cnt_t'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO with destination filtering
    // ------------------------------------------------------------------
    logic [bits-1:0] rx_mem [depth];
    ptr_t            rx_wr_ptr;
    ptr_t            rx_rd_ptr;
    cnt_t            rx_count;
    logic [7:0]      push_dest;
    logic            push_addressed;
    logic            rx_full;
    logic            rx_store;
    logic            rx_drop;
    logic            rx_read;

    assign push_dest      = D_push[bits-1 -: 8];
    assign push_addressed = push && ((push_dest == id) || (push_dest == broadcast));
    // Fullness is judged on the pre-edge count: a same-cycle read does not make room.
    assign rx_full        = (rx_count == depth_c);
    assign rx_store       = push_addressed && !rx_full;
    assign rx_drop        = push_addressed && rx_full;

    assign rx_valid = (rx_count != '0);
    assign rx_read  = rx_valid && rx_ready;
    assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rx_store) begin
            rx_mem[rx_wr_ptr] <= D_push;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (rx_store) begin
                rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
            end
            if (rx_read) begin
                rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
            end
            case ({rx_store, rx_read})
                2'b10:   rx_count <= rx_count + cnt_t'(1);
                2'b01:   rx_count <= rx_count - cnt_t'(1);
                default: rx_count <= rx_count;
            endcase
            if (rx_drop && (rx_drop_cnt != 8'hFF)) begin
                rx_drop_cnt <= rx_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bs_drvr_endpoint.sv
// Directed table plus hand-written corner sequences and a queue-model random run
// for the bus driver endpoint (id = 8'h03, depth = 8, 32-bit packets).
module tb_bs_drvr_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pndng;
    logic        pop;
    logic [31:0] D_pop;
    logic        push;
    logic [31:0] D_push;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bs_drvr_endpoint #(
        .bits(32), .depth(8), .id(8'h03), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pndng(pndng), .pop(pop), .D_pop(D_pop),
        .push(push), .D_push(D_push),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tx_valid;
        logic [31:0] tx_data;
        logic        pop;
        logic        push;
        logic [31:0] d_push;
        logic        rx_ready;
        logic        exp_pndng;
        logic [31:0] exp_d_pop;
        logic        exp_tx_ready;
        logic        exp_rx_valid;
        logic [31:0] exp_rx_data;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[14];

    // scoreboard state for the random run
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          model_drops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic pn, input logic [31:0] dp,
                                 input logic tr, input logic rv, input logic [31:0] rd,
                                 input logic [7:0] dc);
        check({tag, ".pndng"},       32'(pndng),       32'(pn));
        check({tag, ".D_pop"},       D_pop,            dp);
        check({tag, ".tx_ready"},    32'(tx_ready),    32'(tr));
        check({tag, ".rx_valid"},    32'(rx_valid),    32'(rv));
        check({tag, ".rx_data"},     rx_data,          rd);
        check({tag, ".rx_drop_cnt"}, 32'(rx_drop_cnt), 32'(dc));
    endtask

    task automatic drive(input logic tv, input logic [31:0] td, input logic p,
                         input logic pu, input logic [31:0] dpu, input logic rr);
        tx_valid = tv;
        tx_data  = td;
        pop      = p;
        push     = pu;
        D_push   = dpu;
        rx_ready = rr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {tx_valid, tx_data, pop, push, D_push, rx_ready, pndng, D_pop, tx_ready, rx_valid, rx_data, drop}
        vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0, 8'd0};
        vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0, 8'd0};
        vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 32'h0, 8'd0};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 8'd0};
        vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 8'd0};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h03ABCDEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h03ABCDEF, 8'd0};
        vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hFF000001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h03ABCDEF, 8'd0};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h05000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h03ABCDEF, 8'd0};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFF000001, 8'd0};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0};
        vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0};
        vecs[11] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h03000033, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h03000033, 8'd0};
        vecs[12] = '{1'b1, 32'h44, 1'b1, 1'b1, 32'hFF000044, 1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'hFF000044, 8'd0};
        vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0};

        // ---------------- reset state ----------------
        reset = 1'b1;
        idle();
        tick();
        check_outputs("reset", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0);
        tick();
        reset = 1'b0;
        check_outputs("post_reset", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].tx_valid, vecs[i].tx_data, vecs[i].pop,
                  vecs[i].push, vecs[i].d_push, vecs[i].rx_ready);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pndng, vecs[i].exp_d_pop,
                          vecs[i].exp_tx_ready, vecs[i].exp_rx_valid,
                          vecs[i].exp_rx_data, vecs[i].exp_drop);
        end
        idle();

        // ---------------- RX overflow: 9th push dropped despite same-cycle read ----------------
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h03000000 + 32'(i), 1'b0);
            tick();
        end
        check("rxfull.head", rx_data, 32'h03000000);
        check("rxfull.drop0", 32'(rx_drop_cnt), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h03000008, 1'b1);
        tick();
        check("rxfull.drop1", 32'(rx_drop_cnt), 32'd1);
        idle();
        for (int i = 1; i < 8; i++) begin
            check($sformatf("rxfull.order%0d", i), rx_data, 32'h03000000 + 32'(i));
            rx_ready = 1'b1;
            tick();
        end
        idle();
        check("rxfull.empty_valid", 32'(rx_valid), 32'd0);
        check("rxfull.empty_data", rx_data, 32'h0);

        // ---------------- TX full with simultaneous write and pop ----------------
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        idle();
        check("txfull.ready", 32'(tx_ready), 32'd0);
        check("txfull.head", D_pop, 32'h100);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        check("txfull.ready_after_pop", 32'(tx_ready), 32'd1);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("txfull.order%0d", i), D_pop, 32'h100 + 32'(i));
            pop = 1'b1;
            tick();
        end
        idle();
        check("txfull.empty_pndng", 32'(pndng), 32'd0);
        check("txfull.empty_d_pop", D_pop, 32'h0);
        pop = 1'b1;
        tick();
        idle();
        check("tx.pop_empty_pndng", 32'(pndng), 32'd0);
        drive(1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        check("tx.after_empty_pop", D_pop, 32'h55);
        pop = 1'b1;
        tick();
        idle();

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0, (i < 3), 32'hFF000300 + 32'(i), 1'b0);
            tick();
        end
        idle();
        check("prereset.pndng", 32'(pndng), 32'd1);
        check("prereset.rx_valid", 32'(rx_valid), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 8'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        check_outputs("after_reset", 1'b1, 32'h77, 1'b1, 1'b0, 32'h0, 8'd0);
        pop = 1'b1;
        tick();
        idle();
        check("after_reset.drain", 32'(pndng), 32'd0);

        // ---------------- random concurrent traffic vs queue model ----------------
        model_drops = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        tv, p, pu, rr, addr, rx_rd, tx_rd, tx_wr, store;
            logic [7:0]  dest;
            logic [31:0] td, dpu;
            int          k;
            tv = ($urandom_range(0, 99) < 50);
            p  = ($urandom_range(0, 99) < 45);
            pu = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 25);
            k  = $urandom_range(0, 3);
            case (k)
                0:       dest = 8'h03;
                1:       dest = 8'hFF;
                2:       dest = 8'h05;
                default: dest = 8'h10;
            endcase
            td  = $urandom;
            dpu = {dest, 24'($urandom)};
            drive(tv, td, p, pu, dpu, rr);

            tx_wr = tv && (tx_q.size() < 8);
            tx_rd = p && (tx_q.size() > 0);
            addr  = pu && ((dest == 8'h03) || (dest == 8'hFF));
            store = addr && (rx_q.size() < 8);
            if (addr && !store) model_drops++;
            rx_rd = rr && (rx_q.size() > 0);
            if (tx_rd) void'(tx_q.pop_front());
            if (tx_wr) tx_q.push_back(td);
            if (rx_rd) void'(rx_q.pop_front());
            if (store) rx_q.push_back(dpu);

            tick();
            check_outputs($sformatf("rand%0d", cyc),
                          (tx_q.size() != 0), (tx_q.size() != 0) ? tx_q[0] : 32'h0,
                          (tx_q.size() < 8),
                          (rx_q.size() != 0), (rx_q.size() != 0) ? rx_q[0] : 32'h0,
                          (model_drops > 255) ? 8'hFF : 8'(model_drops));
        end
        idle();
        check("rand.drop_saturated", 32'(rx_drop_cnt), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
